// File: rtl/tcm_arb_ctrl_if.sv
// Bundle of requestor command/response channels and the SRAM macro pins for tcm_arb_ctrl.
// The slave modport is the arbiter; the master modport is the system side (requestors plus SRAM).
interface tcm_arb_ctrl_if #(
  parameter int NCH = 2,
  parameter int AW  = 14,
  parameter int DW  = 32
);
  localparam int MW  = DW / 8;
  localparam int BAW = AW + $clog2(MW);

  logic [NCH-1:0]     cmd_valid;
  logic [NCH-1:0]     cmd_ready;
  logic [NCH-1:0]     cmd_read;
  logic [NCH*BAW-1:0] cmd_addr;
  logic [NCH*DW-1:0]  cmd_wdata;
  logic [NCH*MW-1:0]  cmd_wmask;
  logic [NCH-1:0]     rsp_valid;
  logic [NCH-1:0]     rsp_ready;
  logic [NCH*DW-1:0]  rsp_rdata;
  logic               ram_cs;
  logic               ram_we;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_din;
  logic [MW-1:0]      ram_wem;
  logic [DW-1:0]      ram_dout;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready, ram_dout,
    input  cmd_ready, rsp_valid, rsp_rdata, ram_cs, ram_we, ram_addr, ram_din, ram_wem
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready, ram_dout,
    output cmd_ready, rsp_valid, rsp_rdata, ram_cs, ram_we, ram_addr, ram_din, ram_wem
  );
endinterface

// File: rtl/tcm_arb_ctrl.sv
// NCH-channel arbiter onto one single-port synchronous SRAM with per-channel response holding.
// Define TCM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module tcm_arb_ctrl #(
  parameter int NCH = 2,
  parameter int AW  = 14,
  parameter int DW  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  tcm_arb_ctrl_if.slave bus
);
  localparam int MW  = DW / 8;
  localparam int BAW = AW + $clog2(MW);

  logic [NCH-1:0] eligible;
  logic [NCH-1:0] req;
  logic [NCH-1:0] grant;
  logic           found;

  logic [NCH-1:0] rsp_valid_q, rsp_valid_d;
  logic [NCH-1:0] first_q, first_d;
  logic [NCH-1:0] is_read_q, is_read_d;
  logic [DW-1:0]  hold_q [NCH];
  logic [DW-1:0]  hold_d [NCH];

  // A channel may issue again in the same cycle its previous response drains.
  always_comb begin
    eligible = bus.cmd_valid & (~rsp_valid_q | bus.rsp_ready);
  end

`ifdef TCM_ARB_RR_EN
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0] above_ptr;
  logic [NCH-1:0] req_hi;

  // Channels above the pointer take precedence; wrap to the full set if none of them ask.
  always_comb begin
    above_ptr = '0;
    for (int i = 0; i < NCH; i++) begin
      above_ptr[i] = (PW'(i) > ptr_q);
    end
    req_hi = eligible & above_ptr;
    req    = (|req_hi) ? req_hi : eligible;
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        ptr_d = PW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PW'(NCH - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    req = eligible;
  end
`endif

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign bus.cmd_ready = grant;

  always_comb begin
    bus.ram_cs   = |grant;
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    bus.ram_wem  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        bus.ram_we   = ~bus.cmd_read[i];
        bus.ram_addr = bus.cmd_addr[i*BAW + (BAW - AW) +: AW];
        bus.ram_din  = bus.cmd_wdata[i*DW +: DW];
        bus.ram_wem  = bus.cmd_read[i] ? '0 : bus.cmd_wmask[i*MW +: MW];
      end
    end
  end

  // ram_dout is only trustworthy in the first response cycle, so it is banked then.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      rsp_valid_d[i] = rsp_valid_q[i];
      first_d[i]     = 1'b0;
      is_read_d[i]   = is_read_q[i];
      hold_d[i]      = hold_q[i];
      if (first_q[i] && is_read_q[i]) begin
        hold_d[i] = bus.ram_dout;
      end
      if (grant[i]) begin
        rsp_valid_d[i] = 1'b1;
        first_d[i]     = 1'b1;
        is_read_d[i]   = bus.cmd_read[i];
      end else if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    bus.rsp_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (is_read_q[i]) begin
        bus.rsp_rdata[i*DW +: DW] = first_q[i] ? bus.ram_dout : hold_q[i];
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      first_q     <= '0;
      is_read_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      rsp_valid_q <= rsp_valid_d;
      first_q     <= first_d;
      is_read_q   <= is_read_d;
      for (int i = 0; i < NCH; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end
endmodule

// File: tb/tb_tcm_arb_ctrl.sv
// Directed bench for tcm_arb_ctrl (NCH=2, AW=14, DW=32) with a behavioural SRAM model.
// Expectations follow the TCM_ARB_RR_EN build selection where arbitration order matters.
module tb_tcm_arb_ctrl;
`ifdef TCM_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic clk;
  logic rst_n;

  tcm_arb_ctrl_if #(.NCH(2), .AW(14), .DW(32)) bus ();

  tcm_arb_ctrl #(.NCH(2), .AW(14), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: writes leave garbage on dout so stale-bypass bugs show up.
  logic [31:0] mem [0:(1<<14)-1];
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.ram_wem[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
        end
        bus.ram_dout <= ~bus.ram_din;
      end else begin
        bus.ram_dout <= mem[bus.ram_addr];
      end
    end
  end

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  read;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [3:0]  wm0;
    logic [3:0]  wm1;
    logic [1:0]  rready;
    logic [1:0]  e_ready;
    logic [1:0]  e_rv;
    logic        e_cs;
    logic        e_we;
    logic [13:0] e_addr;
    logic [31:0] e_din;
    logic [3:0]  e_wem;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
  } vec_t;

  int    nCompared;
  int    nMismatched;
  string curTag;
  vec_t  tbl [8];

  function automatic vec_t mkVec(
    input logic [1:0] valid, input logic [1:0] read,
    input logic [15:0] a0, input logic [15:0] a1,
    input logic [31:0] wd0, input logic [31:0] wd1,
    input logic [3:0] wm0, input logic [3:0] wm1, input logic [1:0] rready,
    input logic [1:0] e_ready, input logic [1:0] e_rv, input logic e_cs, input logic e_we,
    input logic [13:0] e_addr, input logic [31:0] e_din, input logic [3:0] e_wem,
    input logic [31:0] e_rd0, input logic [31:0] e_rd1);
    vec_t v;
    v.valid = valid;  v.read = read;  v.a0 = a0;  v.a1 = a1;
    v.wd0 = wd0;  v.wd1 = wd1;  v.wm0 = wm0;  v.wm1 = wm1;  v.rready = rready;
    v.e_ready = e_ready;  v.e_rv = e_rv;  v.e_cs = e_cs;  v.e_we = e_we;
    v.e_addr = e_addr;  v.e_din = e_din;  v.e_wem = e_wem;
    v.e_rd0 = e_rd0;  v.e_rd1 = e_rd1;
    return v;
  endfunction

  function automatic vec_t idleVec(input logic [1:0] e_rv, input logic [31:0] e_rd0,
                                   input logic [31:0] e_rd1);
    return mkVec(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11,
                 2'b00, e_rv, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, e_rd0, e_rd1);
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s/%s: got %h expected %h", curTag, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.cmd_valid = v.valid;
    bus.cmd_read  = v.read;
    bus.cmd_addr  = {v.a1, v.a0};
    bus.cmd_wdata = {v.wd1, v.wd0};
    bus.cmd_wmask = {v.wm1, v.wm0};
    bus.rsp_ready = v.rready;
  endtask

  task automatic checkOutput(input vec_t v);
    checkVal("cmd_ready", 64'(bus.cmd_ready), 64'(v.e_ready));
    checkVal("rsp_valid", 64'(bus.rsp_valid), 64'(v.e_rv));
    checkVal("ram_cs", 64'(bus.ram_cs), 64'(v.e_cs));
    checkVal("ram_we", 64'(bus.ram_we), 64'(v.e_we));
    checkVal("ram_wem", 64'(bus.ram_wem), 64'(v.e_wem));
    if (v.e_cs) checkVal("ram_addr", 64'(bus.ram_addr), 64'(v.e_addr));
    if (v.e_we) checkVal("ram_din", 64'(bus.ram_din), 64'(v.e_din));
    if (v.e_rv[0]) checkVal("rsp_rdata0", 64'(bus.rsp_rdata[31:0]), 64'(v.e_rd0));
    if (v.e_rv[1]) checkVal("rsp_rdata1", 64'(bus.rsp_rdata[63:32]), 64'(v.e_rd1));
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(v);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    clk         = 1'b0;
    rst_n       = 1'b0;

    // Single-channel write/read, then byte-masked merge with a misaligned address.
    tbl[0] = mkVec(2'b01, 2'b00, 16'h0040, 16'h0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0, 2'b11,
                   2'b01, 2'b00, 1'b1, 1'b1, 14'h010, 32'hDEADBEEF, 4'hF, 32'h0, 32'h0);
    tbl[1] = mkVec(2'b01, 2'b01, 16'h0040, 16'h0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11,
                   2'b01, 2'b01, 1'b1, 1'b0, 14'h010, 32'h0, 4'h0, 32'h0, 32'h0);
    tbl[2] = idleVec(2'b01, 32'hDEADBEEF, 32'h0);
    tbl[3] = mkVec(2'b10, 2'b00, 16'h0, 16'h0080, 32'h0, 32'h11223344, 4'h0, 4'hF, 2'b11,
                   2'b10, 2'b00, 1'b1, 1'b1, 14'h020, 32'h11223344, 4'hF, 32'h0, 32'h0);
    tbl[4] = mkVec(2'b10, 2'b00, 16'h0, 16'h0081, 32'h0, 32'hAABBCCDD, 4'h0, 4'h5, 2'b11,
                   2'b10, 2'b10, 1'b1, 1'b1, 14'h020, 32'hAABBCCDD, 4'h5, 32'h0, 32'h0);
    tbl[5] = mkVec(2'b10, 2'b10, 16'h0, 16'h0080, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11,
                   2'b10, 2'b10, 1'b1, 1'b0, 14'h020, 32'h0, 4'h0, 32'h0, 32'h0);
    tbl[6] = idleVec(2'b10, 32'h0, 32'h11BB33DD);
    tbl[7] = idleVec(2'b00, 32'h0, 32'h0);

    applyStimulus(idleVec(2'b00, 32'h0, 32'h0));
    repeat (2) @(negedge clk);
    curTag = "reset";
    checkVal("rsp_valid", 64'(bus.rsp_valid), 64'h0);
    checkVal("ram_cs", 64'(bus.ram_cs), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      curTag = $sformatf("tbl%0d", i);
      step(tbl[i]);
    end

    // Throughput: preload 8 words through ch1, then 8 back-to-back reads on ch0.
    curTag = "thru_pre";
    for (int k = 0; k < 8; k++) begin
      step(mkVec(2'b10, 2'b00, 16'h0, 16'(16'h0400 + 4*k), 32'h0, 32'(32'hA5000000 + k),
                 4'h0, 4'hF, 2'b11, 2'b10, (k == 0) ? 2'b00 : 2'b10, 1'b1, 1'b1,
                 14'(14'h100 + k), 32'(32'hA5000000 + k), 4'hF, 32'h0, 32'h0));
    end
    step(idleVec(2'b10, 32'h0, 32'h0));
    curTag = "thru_rd";
    for (int k = 0; k < 8; k++) begin
      step(mkVec(2'b01, 2'b01, 16'(16'h0400 + 4*k), 16'h0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11,
                 2'b01, (k == 0) ? 2'b00 : 2'b01, 1'b1, 1'b0, 14'(14'h100 + k), 32'h0, 4'h0,
                 (k == 0) ? 32'h0 : 32'(32'hA5000000 + k - 1), 32'h0));
    end
    step(idleVec(2'b01, 32'hA5000007, 32'h0));
    step(idleVec(2'b00, 32'h0, 32'h0));

    // Backpressure: ch1 read held 3 cycles while ch0 writes elsewhere.
    curTag = "bp_pre";
    step(mkVec(2'b10, 2'b00, 16'h0, 16'h00C0, 32'h0, 32'hCAFEF00D, 4'h0, 4'hF, 2'b11,
               2'b10, 2'b00, 1'b1, 1'b1, 14'h030, 32'hCAFEF00D, 4'hF, 32'h0, 32'h0));
    step(mkVec(2'b10, 2'b00, 16'h0, 16'h00C4, 32'h0, 32'h0BADCAFE, 4'h0, 4'hF, 2'b11,
               2'b10, 2'b10, 1'b1, 1'b1, 14'h031, 32'h0BADCAFE, 4'hF, 32'h0, 32'h0));
    step(idleVec(2'b10, 32'h0, 32'h0));
    step(idleVec(2'b00, 32'h0, 32'h0));
    curTag = "bp";
    step(mkVec(2'b10, 2'b10, 16'h0, 16'h00C0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11,
               2'b10, 2'b00, 1'b1, 1'b0, 14'h030, 32'h0, 4'h0, 32'h0, 32'h0));
    step(mkVec(2'b11, 2'b10, 16'h0200, 16'h00C4, 32'h55555555, 32'h0, 4'hF, 4'h0, 2'b01,
               2'b01, 2'b10, 1'b1, 1'b1, 14'h080, 32'h55555555, 4'hF, 32'h0, 32'hCAFEF00D));
    step(mkVec(2'b11, 2'b10, 16'h0204, 16'h00C4, 32'h66666666, 32'h0, 4'hF, 4'h0, 2'b01,
               2'b01, 2'b11, 1'b1, 1'b1, 14'h081, 32'h66666666, 4'hF, 32'h0, 32'hCAFEF00D));
    step(mkVec(2'b10, 2'b10, 16'h0, 16'h00C4, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01,
               2'b00, 2'b11, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D));
    step(mkVec(2'b10, 2'b10, 16'h0, 16'h00C4, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11,
               2'b10, 2'b10, 1'b1, 1'b0, 14'h031, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D));
    step(idleVec(2'b10, 32'h0, 32'h0BADCAFE));
    step(idleVec(2'b00, 32'h0, 32'h0));

    // Reset with both responses pending, then first contention after release.
    curTag = "rst_pre";
    step(mkVec(2'b01, 2'b00, 16'h0140, 16'h0, 32'h50505050, 32'h0, 4'hF, 4'h0, 2'b11,
               2'b01, 2'b00, 1'b1, 1'b1, 14'h050, 32'h50505050, 4'hF, 32'h0, 32'h0));
    step(mkVec(2'b01, 2'b00, 16'h0144, 16'h0, 32'h51515151, 32'h0, 4'hF, 4'h0, 2'b11,
               2'b01, 2'b01, 1'b1, 1'b1, 14'h051, 32'h51515151, 4'hF, 32'h0, 32'h0));
    step(idleVec(2'b01, 32'h0, 32'h0));
    step(mkVec(2'b01, 2'b01, 16'h0140, 16'h0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00,
               2'b01, 2'b00, 1'b1, 1'b0, 14'h050, 32'h0, 4'h0, 32'h0, 32'h0));
    step(mkVec(2'b10, 2'b10, 16'h0, 16'h0144, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00,
               2'b10, 2'b01, 1'b1, 1'b0, 14'h051, 32'h0, 4'h0, 32'h50505050, 32'h0));
    step(mkVec(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00,
               2'b00, 2'b11, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 32'h50505050, 32'h51515151));
    #1 rst_n = 1'b0;
    #1;
    curTag = "rst_async";
    checkVal("rsp_valid", 64'(bus.rsp_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    curTag = "contend";
    for (int k = 0; k < 4; k++) begin
      logic g1, p1;
      g1 = RR_BUILD && (k % 2 == 1);
      p1 = RR_BUILD && (k % 2 == 0);
      step(mkVec(2'b11, 2'b11, 16'h0140, 16'h0144, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11,
                 g1 ? 2'b10 : 2'b01, (k == 0) ? 2'b00 : (p1 ? 2'b10 : 2'b01), 1'b1, 1'b0,
                 g1 ? 14'h051 : 14'h050, 32'h0, 4'h0, 32'h50505050, 32'h51515151));
    end
    step(idleVec(RR_BUILD ? 2'b10 : 2'b01, 32'h50505050, 32'h51515151));
    step(idleVec(2'b00, 32'h0, 32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/tcm_arb_ctrl.md
Name: tcm_arb_ctrl

Overview:
- Parametrised successor to the single-requestor ITCM/DTCM controllers. Arbitrates NCH valid/ready command channels onto one single-port synchronous SRAM.
- Returns each response to the channel that issued the command. Each channel holds its own response until the requestor accepts it.
- Target use: a shared unified TCM, for example IFU and LSU on one SRAM, plus a debug or DMA port.
- Sits between core-side buses and the SRAM macro in the cpu top.

Parameters:
- NCH, 2, number of requestor channels (1..8)
- AW, 14, SRAM word-address width
- DW, 32, data width (multiple of 8)
- MW, DW/8, byte write-mask width (derived, not overridable)
- BAW, AW+$clog2(MW), byte-address width on command ports (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  NCH  per-channel command valid
- cmd_ready  out  NCH  per-channel command accept
- cmd_read  in  NCH  1=read, 0=write
- cmd_addr  in  NCH*BAW  byte addresses, channel i at [i*BAW +: BAW]
- cmd_wdata  in  NCH*DW  write data
- cmd_wmask  in  NCH*MW  byte write enables
- rsp_valid  out  NCH  per-channel response valid
- rsp_ready  in  NCH  per-channel response accept
- rsp_rdata  out  NCH*DW  read data (0 for write responses)
- ram_cs  out  1  SRAM chip select
- ram_we  out  1  SRAM write enable
- ram_addr  out  AW  SRAM word address
- ram_din  out  DW  SRAM write data
- ram_wem  out  MW  SRAM byte mask
- ram_dout  in  DW  SRAM read data, valid one cycle after a read with ram_cs=1

Behaviour:
- Clock/reset: one clock `clk`. Reset `rst_n` is asynchronous, active-low. All state clears on reset.
- Reset values: rsp_valid=0, first/hold flags=0, hold registers=0, round-robin pointer=NCH-1 so channel 0 is favoured first.
- ram_* outputs are combinational from the grant. With no grant: ram_cs=0, ram_we=0, ram_wem=0.
- Eligibility: channel i is eligible when cmd_valid[i] && (!rsp_valid[i] || rsp_ready[i]). One response per channel is outstanding at most.
- Grant: at most one grant per cycle, one-hot among eligible channels. cmd_ready[i] = grant[i].
  - cmd_ready may depend on cmd_valid.
  - Requestors must not make cmd_valid depend on cmd_ready.
  - Once a requestor asserts cmd_valid, its command stays stable until accepted.
- On grant at cycle T:
  - ram_cs=1 and ram_addr=cmd_addr[i][BAW-1:$clog2(MW)].
  - Write: ram_we=1, ram_din=cmd_wdata[i], ram_wem=cmd_wmask[i].
  - Read: ram_we=0, ram_wem=0.
- Response timing: rsp_valid[i] rises at T+1, giving 1-cycle latency.
  - Read, first response cycle: rsp_rdata[i]=ram_dout (bypass).
  - If not accepted in that cycle, ram_dout is captured into hold[i]. rsp_rdata[i] then comes from hold[i] until acceptance.
  - Write: rsp_rdata[i]=0.
- rsp_valid[i] clears on rsp_valid&&rsp_ready unless the same channel was re-granted that cycle. Back-to-back responses are allowed, giving 1 transaction/cycle aggregate throughput.
- Response data stays stable while rsp_valid=1 and rsp_ready=0. Another channel's SRAM access must not corrupt it.
- Round-robin pointer updates to the granted index on every grant and holds otherwise.
- Simultaneous read and write from different channels: the arbiter serialises them. There is no write-to-read forwarding; ordering is grant order.
- Misaligned low address bits are ignored and wmask defines the bytes.
- Reset asserted mid-transaction: all in-flight responses are dropped and rsp_valid goes to 0 immediately. The SRAM write in progress is not guaranteed.

Optional Feature:
- Macro TCM_ARB_RR_EN.
  - Defined: round-robin arbitration, searching from pointer+1 upward with wrap; the pointer register exists.
  - Undefined: fixed priority, lowest index wins; no pointer register.
- Everything else is identical in both builds.

Test Plan:
- Single-channel path: ch0 writes 0xDEADBEEF to byte addr 0x40 with mask 0xF, then reads 0x40 -> ram_addr=0x10 on both commands. Read rsp_rdata[0]=0xDEADBEEF one cycle after grant.
- Byte masking: preload 0x11223344, write 0xAABBCCDD with mask 0x5 -> read back 0x11BB33DD.
- Contention: ch0 and ch1 both hold valid reads for 4 cycles.
  - RR build: grants alternate 0,1,0,1.
  - Fixed build: ch0 is granted on every cycle its response is drained.
- Backpressure: ch1 reads 0xCAFEF00D with rsp_ready=0 for 3 cycles while ch0 writes elsewhere -> rsp_rdata[1] stays 0xCAFEF00D and ch1 is not granted again until acceptance.
- Throughput: ch0 issues 8 back-to-back reads with rsp_ready=1 -> 8 responses in 8 consecutive cycles.
- Reset mid-burst: assert rst_n=0 asynchronously with rsp_valid=2'b11 -> rsp_valid=0 before the next clk edge. After release, ch0 wins the first contention in both builds.
